// File: rtl/cordic_rotator_pkg.sv
// Shared constants and FSM state type for the CORDIC direction-replay rotator.
package cordic_rotator_pkg;

  localparam int unsigned CR_WIDTH    = 12;
  localparam int unsigned CR_NUM_ITER = 6;
  localparam int unsigned CR_ONE      = 256;  // 1.0 in S3.8

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_rotator_if.sv
// Pair/direction handshake bundle between a producer and the CORDIC rotator.
interface cordic_rotator_if
  import cordic_rotator_pkg::*;
#(
  parameter int unsigned WIDTH    = CR_WIDTH,
  parameter int unsigned NUM_ITER = CR_NUM_ITER
);

  logic                    i_dir_load;
  logic [NUM_ITER:0]       i_dir;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_x;
  logic signed [WIDTH-1:0] i_y;
  logic                    o_ready;
  logic                    o_valid;
  logic signed [WIDTH-1:0] o_x;
  logic signed [WIDTH-1:0] o_y;
  logic                    i_ready;

  modport master (
    output i_dir_load, i_dir, i_valid, i_x, i_y, i_ready,
    input  o_ready, o_valid, o_x, o_y
  );

  modport slave (
    input  i_dir_load, i_dir, i_valid, i_x, i_y, i_ready,
    output o_ready, o_valid, o_x, o_y
  );

endinterface

// File: rtl/cordic_kn_scale.sv
// Combinational CORDIC gain compensation; CORDIC_ROTATOR_FINE_KN_EN selects the
// five-term ~0.6055 constant, otherwise the two-term 0.625 constant is used.
module cordic_kn_scale
  import cordic_rotator_pkg::*;
#(
  parameter int unsigned WIDTH = CR_WIDTH
) (
  input  logic signed [WIDTH-1:0] v,
  output logic signed [WIDTH-1:0] scaled_c
);

  always_comb begin
`ifdef CORDIC_ROTATOR_FINE_KN_EN
    scaled_c = (v >>> 1) + (v >>> 4) + (v >>> 5) + (v >>> 7) + (v >>> 8);
`else
    scaled_c = (v >>> 1) + (v >>> 3);
`endif
  end

endmodule

// File: rtl/cordic_rotator.sv
// Replays a stored CORDIC direction word onto input pairs, one pair at a time.
// Gain constant is selected by CORDIC_ROTATOR_FINE_KN_EN (see cordic_kn_scale).
module cordic_rotator
  import cordic_rotator_pkg::*;
#(
  parameter int unsigned WIDTH    = CR_WIDTH,
  parameter int unsigned NUM_ITER = CR_NUM_ITER
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cordic_rotator_if.slave  bus
);

  localparam int unsigned CNT_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

  state_t                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic                    last_q;
  logic [NUM_ITER:0]       dir_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] y_q;
  logic signed [WIDTH-1:0] ox_q;
  logic signed [WIDTH-1:0] oy_q;
  logic                    ready_q;
  logic                    valid_q;

  logic [NUM_ITER:0]       dir_eff_c;
  logic signed [WIDTH-1:0] x_shift_c;
  logic signed [WIDTH-1:0] y_shift_c;
  logic signed [WIDTH-1:0] x_kn_c;
  logic signed [WIDTH-1:0] y_kn_c;

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_x     = ox_q;
  assign bus.o_y     = oy_q;

  // A load in the same cycle as the pair governs that pair.
  always_comb begin
    dir_eff_c = bus.i_dir_load ? bus.i_dir : dir_q;
    x_shift_c = x_q >>> count_q;
    y_shift_c = y_q >>> count_q;
  end

  cordic_kn_scale #(.WIDTH(WIDTH)) u_kn_x (.v(x_q), .scaled_c(x_kn_c));
  cordic_kn_scale #(.WIDTH(WIDTH)) u_kn_y (.v(y_q), .scaled_c(y_kn_c));

  // last_q marks that the final micro-rotation is done and the scaled pair is due.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= 1'b0;
      dir_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_dir_load) begin
            dir_q <= bus.i_dir;
          end
          if (bus.i_valid) begin
            x_q     <= dir_eff_c[NUM_ITER] ? -bus.i_x : bus.i_x;
            y_q     <= dir_eff_c[NUM_ITER] ? -bus.i_y : bus.i_y;
            count_q <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (last_q) begin
            ox_q    <= x_kn_c;
            oy_q    <= y_kn_c;
            valid_q <= 1'b1;
            state_q <= ST_OUT;
          end else begin
            if (dir_q[count_q]) begin
              x_q <= x_q - y_shift_c;
              y_q <= y_q + x_shift_c;
            end else begin
              x_q <= x_q + y_shift_c;
              y_q <= y_q - x_shift_c;
            end
            if (count_q == CNT_W'(NUM_ITER - 1)) begin
              last_q <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
